// File: rtl/mult_datapath_8bit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_datapath_8bit
//  Purpose  : Shift-and-add datapath for the 8-bit unsigned multiplier.
//             Executes shift-register, accumulator and capture commands
//             issued by the external multiply controller. It contains no
//             sequencing of its own.
//  Ports    : clk           - system clock, rising edge
//             rst_n         - synchronous active-low reset
//             A, B          - multiplicand / multiplier (sampled on load)
//             sr_sel[1:0]   - 0 hold, 1 load, 2 shift left, 3 hold
//             acc_ld        - acc <= acc + sr
//             acc_clr       - acc <= 0 (wins over acc_ld)
//             done          - product <= acc, product_valid <= 1
//             b_q           - latched multiplier, returned to controller
//             product       - held 2W-bit result
//             product_valid - product holds a completed result
//  Revision : 1.0 - initial release
// ============================================================================
module mult_datapath_8bit #(
   parameter int W = 8   // only 8 matches the controller
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic [1:0]     sr_sel,
   input  logic           acc_ld,
   input  logic           acc_clr,
   input  logic           done,
   output logic [W-1:0]   b_q,
   output logic [2*W-1:0] product,
   output logic           product_valid
);

   localparam logic [1:0] c_SR_HOLD  = 2'd0;
   localparam logic [1:0] c_SR_LOAD  = 2'd1;
   localparam logic [1:0] c_SR_SHIFT = 2'd2;

   logic [2*W-1:0] r_sr;
   logic [2*W-1:0] r_acc;
   logic [W-1:0]   r_b_q;
   logic [2*W-1:0] r_product;
   logic           r_product_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sr            <= '0;
         r_acc           <= '0;
         r_b_q           <= '0;
         r_product       <= '0;
         r_product_valid <= 1'b0;
      end else begin
         // Shift register and multiplier latch
         case (sr_sel)
            c_SR_LOAD: begin
               r_sr  <= {{W{1'b0}}, A};
               r_b_q <= B;
            end
            c_SR_SHIFT: r_sr <= r_sr << 1;
            c_SR_HOLD:  r_sr <= r_sr;
            default:    r_sr <= r_sr;   // reserved code holds
         endcase

         // Accumulator: the add uses the pre-shift sr, so an add that
         // coincides with a shift contributes A*2^i for bit i.
         if (acc_clr)
            r_acc <= '0;
         else if (acc_ld)
            r_acc <= r_acc + r_sr;

         // Capture sees acc before any same-cycle update. A simultaneous
         // done and load is illegal from the controller; done wins so the
         // valid flag is deterministic.
         if (done) begin
            r_product       <= r_acc;
            r_product_valid <= 1'b1;
         end else if (sr_sel == c_SR_LOAD) begin
            r_product_valid <= 1'b0;
         end
      end
   end

   assign b_q           = r_b_q;
   assign product       = r_product;
   assign product_valid = r_product_valid;

endmodule
`default_nettype wire
